block_row: RTL and testbench

//  Parametrised row of N_BLOCKS breakable Breakout blocks, each with its own hit-point counter.

---
 rtl/block_row.sv | 189 ++++++++++++++++++
 tb/tb_block_row.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/block_row.sv
// rtl/block_row.sv - row of breakable blocks with per-block hit points, edge contact, hit hold-off and optional descent
// Optional descent is built when BLOCK_ROW_DESCEND_EN is defined.
module block_row #(
  parameter int N_BLOCKS      = 4,
  parameter int W_BLOCK       = 64,
  parameter int H_BLOCK       = 16,
  parameter int GAP           = 16,
  parameter int R_BALL        = 8,
  parameter int X0            = 80,
  parameter int Y0            = 64,
  parameter int HP_W          = 2,
  parameter int HP_INIT       = 2,
  parameter int Y_LIMIT       = 464,
  parameter int STEP_Y        = 16,
  parameter int DESCEND_TICKS = 50_000_000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [9:0]          x_ball,
  input  logic [9:0]          y_ball,
  output logic [9:0]          y_row,
  output logic [N_BLOCKS-1:0] alive,
  output logic                hit,
  output logic                hit_u,
  output logic                hit_d,
  output logic                hit_l,
  output logic                hit_r,
  output logic [2:0]          hit_idx,
  output logic                score_inc,
  output logic                row_cleared,
  output logic                endgame
);

  localparam logic [10:0] H11   = 11'(H_BLOCK);
  localparam logic [10:0] W11   = 11'(W_BLOCK);
  localparam logic [10:0] HR11  = 11'(H_BLOCK + R_BALL);
  localparam logic [10:0] WR11  = 11'(W_BLOCK + R_BALL);
  localparam logic [10:0] YLIM11 = 11'(Y_LIMIT);

  if (N_BLOCKS < 1 || N_BLOCKS > 8 || HP_INIT < 1 || HP_INIT >= (1 << HP_W) ||
      DESCEND_TICKS < 1 || STEP_Y < 1) begin : g_param_check
    $error("block_row: parameter out of range");
  end

  typedef enum logic {RUN, HOLD} state_t;
  state_t state, state_next;

  logic [HP_W-1:0]     hp [N_BLOCKS];
  logic [2:0]          held_idx;
  logic [N_BLOCKS-1:0] c_u, c_d, c_l, c_r, contact;
  logic [10:0]         xb, yb, yr, cx, y_top, y_bot, y_up, y_dn, x_lo, x_hi, x_lf, x_rt;
  logic [2:0]          win_idx;
  logic [3:0]          win_side;
  logic                held_contact, take_hit;

  // Lower bounds clamp to 0 instead of wrapping.
  function automatic logic [10:0] sub0(input logic [10:0] a, input logic [10:0] b);
    return (a >= b) ? (a - b) : 11'd0;
  endfunction

  always_comb begin
    xb    = {1'b0, x_ball};
    yb    = {1'b0, y_ball};
    yr    = {1'b0, y_row};
    y_top = sub0(yr, H11);
    y_bot = yr + H11;
    y_up  = sub0(yr, HR11);
    y_dn  = yr + HR11;
    cx    = '0;
    x_lo  = '0;
    x_hi  = '0;
    x_lf  = '0;
    x_rt  = '0;
    c_u   = '0;
    c_d   = '0;
    c_l   = '0;
    c_r   = '0;
    for (int i = 0; i < N_BLOCKS; i++) begin
      cx     = 11'(X0 + i * (2 * W_BLOCK + GAP));
      x_lo   = sub0(cx, W11);
      x_hi   = cx + W11;
      x_lf   = sub0(cx, WR11);
      x_rt   = cx + WR11;
      c_u[i] = alive[i] && (yb == y_up) && (xb >= x_lo) && (xb <= x_hi);
      c_d[i] = alive[i] && (yb == y_dn) && (xb >= x_lo) && (xb <= x_hi);
      c_l[i] = alive[i] && (xb == x_lf) && (yb >= y_top) && (yb <= y_bot);
      c_r[i] = alive[i] && (xb == x_rt) && (yb >= y_top) && (yb <= y_bot);
    end
    contact = c_u | c_d | c_l | c_r;
  end

  // Walk from the top index down so the lowest contacting block wins.
  always_comb begin
    win_idx      = '0;
    win_side     = '0;
    held_contact = 1'b0;
    for (int i = N_BLOCKS - 1; i >= 0; i--) begin
      if (contact[i]) begin
        win_idx  = 3'(i);
        win_side = c_u[i] ? 4'b1000 : c_d[i] ? 4'b0100 : c_l[i] ? 4'b0010 : 4'b0001;
      end
      if (held_idx == 3'(i)) held_contact = contact[i];
    end
  end

  always_comb begin
    state_next = state;
    take_hit   = 1'b0;
    if (!start) begin
      state_next = RUN;
    end else begin
      case (state)
        RUN: begin
          if (|contact) begin
            state_next = HOLD;
            take_hit   = 1'b1;
          end
        end
        HOLD: begin
          if (!held_contact) state_next = RUN;
        end
        default: state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      alive     <= '1;
      held_idx  <= '0;
      hit       <= 1'b0;
      hit_u     <= 1'b0;
      hit_d     <= 1'b0;
      hit_l     <= 1'b0;
      hit_r     <= 1'b0;
      hit_idx   <= '0;
      score_inc <= 1'b0;
      for (int i = 0; i < N_BLOCKS; i++) hp[i] <= HP_W'(HP_INIT);
    end else begin
      state     <= state_next;
      hit       <= take_hit;
      hit_u     <= take_hit & win_side[3];
      hit_d     <= take_hit & win_side[2];
      hit_l     <= take_hit & win_side[1];
      hit_r     <= take_hit & win_side[0];
      score_inc <= 1'b0;
      if (take_hit) begin
        held_idx <= win_idx;
        hit_idx  <= win_idx;
        for (int i = 0; i < N_BLOCKS; i++) begin
          if (win_idx == 3'(i)) begin
            hp[i] <= hp[i] - 1'b1;
            if (hp[i] == HP_W'(1)) begin
              alive[i]  <= 1'b0;
              score_inc <= 1'b1;
            end
          end
        end
      end
    end
  end

`ifdef BLOCK_ROW_DESCEND_EN
  localparam int CNT_W = (DESCEND_TICKS > 1) ? $clog2(DESCEND_TICKS) : 1;
  logic [CNT_W-1:0] desc_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      desc_cnt <= '0;
      y_row    <= 10'(Y0);
    end else if (start) begin
      if (desc_cnt == CNT_W'(DESCEND_TICKS - 1)) begin
        desc_cnt <= '0;
        if (!endgame) y_row <= y_row + 10'(STEP_Y);
      end else begin
        desc_cnt <= desc_cnt + 1'b1;
      end
    end
  end
`else
  assign y_row = 10'(Y0);
`endif

  assign row_cleared = (alive == '0);
  assign endgame     = (({1'b0, y_row} + H11) >= YLIM11);

endmodule

// File: tb/tb_block_row.sv
// tb/tb_block_row.sv - directed self-checking bench for block_row
// Descent checks run on a second instance when BLOCK_ROW_DESCEND_EN is defined.
module tb_block_row;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [9:0] x_ball = 10'd1000;
  logic [9:0] y_ball = 10'd1000;
  logic [9:0] y_row;
  logic [3:0] alive;
  logic       hit, hit_u, hit_d, hit_l, hit_r, score_inc, row_cleared, endgame;
  logic [2:0] hit_idx;
  int         total = 0;
  int         bad = 0;

  always #5 clock = ~clock;

  block_row dut (
    .clock(clock), .reset(reset), .start(start), .x_ball(x_ball), .y_ball(y_ball),
    .y_row(y_row), .alive(alive), .hit(hit), .hit_u(hit_u), .hit_d(hit_d),
    .hit_l(hit_l), .hit_r(hit_r), .hit_idx(hit_idx), .score_inc(score_inc),
    .row_cleared(row_cleared), .endgame(endgame)
  );

`ifdef BLOCK_ROW_DESCEND_EN
  logic       f_start = 1'b0;
  logic [9:0] f_y_row;
  logic [3:0] f_alive;
  logic       f_hit, f_hu, f_hd, f_hl, f_hr, f_score, f_clr, f_end;
  logic [2:0] f_idx;

  block_row #(.DESCEND_TICKS(4)) dut_fast (
    .clock(clock), .reset(reset), .start(f_start), .x_ball(10'd1000), .y_ball(10'd1000),
    .y_row(f_y_row), .alive(f_alive), .hit(f_hit), .hit_u(f_hu), .hit_d(f_hd),
    .hit_l(f_hl), .hit_r(f_hr), .hit_idx(f_idx), .score_inc(f_score),
    .row_cleared(f_clr), .endgame(f_end)
  );
`endif

  task automatic step(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    x_ball = 10'd1000;
    y_ball = 10'd1000;
    step(2);
    reset = 1'b0;
  endtask

  task automatic ball(input int x, input int y);
    x_ball = 10'(x);
    y_ball = 10'(y);
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (alive !== 4'b1111) begin bad++; $display("FAIL reset_alive got=%b want=1111", alive); end
    total++; if (y_row !== 10'd64) begin bad++; $display("FAIL reset_y_row got=%0d want=64", y_row); end
    total++; if ({hit, hit_u, hit_d, hit_l, hit_r, score_inc} !== 6'b0) begin bad++; $display("FAIL reset_pulses got=%b want=000000", {hit, hit_u, hit_d, hit_l, hit_r, score_inc}); end
    total++; if (hit_idx !== 3'd0) begin bad++; $display("FAIL reset_hit_idx got=%0d want=0", hit_idx); end
    total++; if ({row_cleared, endgame} !== 2'b00) begin bad++; $display("FAIL reset_levels got=%b want=00", {row_cleared, endgame}); end
  endtask

  task automatic test_first_hit();
    start = 1'b1;
    ball(80, 40);
    step();
    total++; if ({hit, hit_u, hit_d, hit_l, hit_r} !== 5'b11000) begin bad++; $display("FAIL first_hit_flags got=%b want=11000", {hit, hit_u, hit_d, hit_l, hit_r}); end
    total++; if (hit_idx !== 3'd0) begin bad++; $display("FAIL first_hit_idx got=%0d want=0", hit_idx); end
    total++; if (score_inc !== 1'b0) begin bad++; $display("FAIL first_hit_score got=%b want=0", score_inc); end
    total++; if (alive !== 4'b1111) begin bad++; $display("FAIL first_hit_alive got=%b want=1111", alive); end
  endtask

  task automatic test_hold();
    int hits = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (hit) hits++;
    end
    total++; if (hits !== 0) begin bad++; $display("FAIL hold_repeat got=%0d hits want=0", hits); end
    ball(300, 300);
    step();
    ball(80, 40);
    step();
    total++; if ({hit, hit_u} !== 2'b11) begin bad++; $display("FAIL rehit_flags got=%b want=11", {hit, hit_u}); end
    total++; if (alive !== 4'b1110) begin bad++; $display("FAIL rehit_alive got=%b want=1110", alive); end
    total++; if (score_inc !== 1'b1) begin bad++; $display("FAIL rehit_score got=%b want=1", score_inc); end
    step();
    total++; if ({hit, score_inc} !== 2'b00) begin bad++; $display("FAIL pulse_width got=%b want=00", {hit, score_inc}); end
  endtask

  task automatic test_dead_block();
    int hits = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (hit) hits++;
    end
    total++; if (hits !== 0) begin bad++; $display("FAIL dead_block_hit got=%0d want=0", hits); end
    ball(152, 64);
    step();
    total++; if ({hit, hit_u, hit_d, hit_l, hit_r} !== 5'b10010) begin bad++; $display("FAIL dead_skip_flags got=%b want=10010", {hit, hit_u, hit_d, hit_l, hit_r}); end
    total++; if (hit_idx !== 3'd1) begin bad++; $display("FAIL dead_skip_idx got=%0d want=1", hit_idx); end
  endtask

  task automatic test_priority();
    do_reset();
    start = 1'b1;
    ball(152, 64);
    step();
    total++; if ({hit, hit_u, hit_d, hit_l, hit_r} !== 5'b10001) begin bad++; $display("FAIL prio_flags got=%b want=10001", {hit, hit_u, hit_d, hit_l, hit_r}); end
    total++; if (hit_idx !== 3'd0) begin bad++; $display("FAIL prio_idx got=%0d want=0", hit_idx); end
    ball(80, 88);
    step(2);
    ball(80, 1000);
    step();
    ball(80, 88);
    step();
    total++; if ({hit, hit_d, hit_idx} !== 5'b11000) begin bad++; $display("FAIL bottom_hit got=%b want=11000", {hit, hit_d, hit_idx}); end
  endtask

  task automatic test_clear();
    int scores = 0;
    int hits = 0;
    do_reset();
    start = 1'b1;
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 2; k++) begin
        ball(80 + 144 * b, 40);
        step();
        total++; if ({hit, hit_idx} !== {1'b1, 3'(b)}) begin bad++; $display("FAIL clear_hit b=%0d k=%0d got=%b want=%b", b, k, {hit, hit_idx}, {1'b1, 3'(b)}); end
        if (score_inc) scores++;
        ball(300, 300);
        step();
      end
    end
    total++; if (scores !== 4) begin bad++; $display("FAIL clear_score got=%0d want=4", scores); end
    total++; if ({row_cleared, alive} !== 5'b10000) begin bad++; $display("FAIL cleared got=%b want=10000", {row_cleared, alive}); end
    for (int b = 0; b < 4; b++) begin
      ball(80 + 144 * b, 40); step(); if (hit) hits++;
      ball(16 + 144 * b - 8, 64); step(); if (hit) hits++;
    end
    total++; if (hits !== 0) begin bad++; $display("FAIL cleared_no_hit got=%0d want=0", hits); end
  endtask

  task automatic test_start_low();
    do_reset();
    ball(80, 40);
    step(3);
    total++; if (hit !== 1'b0) begin bad++; $display("FAIL start_low_hit got=%b want=0", hit); end
    start = 1'b1;
    step();
    total++; if (hit !== 1'b1) begin bad++; $display("FAIL start_high_hit got=%b want=1", hit); end
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    total++; if ({hit, score_inc, alive} !== 6'b111110) begin bad++; $display("FAIL start_rearm got=%b want=111110", {hit, score_inc, alive}); end
  endtask

  task automatic test_async_reset();
    do_reset();
    start = 1'b1;
    ball(80, 40);
    step();
    ball(300, 300);
    step();
    ball(80, 40);
    step();
    #2;
    reset = 1'b1;
    #1;
    total++; if (alive !== 4'b1111) begin bad++; $display("FAIL async_alive got=%b want=1111", alive); end
    total++; if (y_row !== 10'd64) begin bad++; $display("FAIL async_y_row got=%0d want=64", y_row); end
    total++; if ({hit, score_inc} !== 2'b00) begin bad++; $display("FAIL async_pulses got=%b want=00", {hit, score_inc}); end
    step();
    reset = 1'b0;
    step();
    total++; if ({hit, hit_u, hit_idx} !== 5'b11000) begin bad++; $display("FAIL after_reset_hit got=%b want=11000", {hit, hit_u, hit_idx}); end
  endtask

`ifdef BLOCK_ROW_DESCEND_EN
  task automatic test_descend();
    int cyc = 0;
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    f_start = 1'b1;
    step(3);
    total++; if (f_y_row !== 10'd64) begin bad++; $display("FAIL descend_early got=%0d want=64", f_y_row); end
    step();
    total++; if (f_y_row !== 10'd80) begin bad++; $display("FAIL descend_step got=%0d want=80", f_y_row); end
    while (!f_end && cyc < 200) begin
      step();
      cyc++;
    end
    total++; if ({f_end, f_y_row} !== {1'b1, 10'd448}) begin bad++; $display("FAIL descend_end got=%b/%0d want=1/448", f_end, f_y_row); end
    step(20);
    total++; if (f_y_row !== 10'd448) begin bad++; $display("FAIL descend_sat got=%0d want=448", f_y_row); end
    f_start = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_first_hit();
    test_hold();
    test_dead_block();
    test_priority();
    test_clear();
    test_start_low();
    test_async_reset();
`ifdef BLOCK_ROW_DESCEND_EN
    test_descend();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
